uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, the receive-side counterpart of uart_tx (same parameter set, same frame format).
//  Oversamples rx_in with the system clock, detects start edge, samples each bit at mid-bit,
//  checks parity/stop, presents a byte with a one-cycle valid strobe. Sits between the pad and the host/FIFO logic.
// PARAMETERS
//  CLK_FREQ   50        clock frequency in MHz; CYCLE = CLK_FREQ*1000000/BAUD_RATE clocks per bit (434 at defaults)
//  BAUD_RATE  115200    bit rate
//  DATA_LEN   8         data bits per frame, 5..8, LSB first
//  PARITY     "NONE"    "NONE"|"ODD"|"EVEN"|"SPACE"|"MARK"; unknown string = "NONE"
//  STOP       "ONE"     "ONE"|"ONEHALF"|"TWO"; receiver checks only the first stop bit for all settings
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  rx_in       in   1  serial line, asynchronous, idle high
//  data_out    out  8  received data; bits [7:DATA_LEN] = 0
//  data_valid  out  1  one-cycle strobe: data_out/parity_err/frame_err updated
//  parity_err  out  1  parity mismatch on last frame (0 when PARITY="NONE")
//  frame_err   out  1  stop bit sampled low on last frame
//  busy        out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, cycle counter=0, bit_ptr=0; sync flops=1.
//  rx_in passes a 2-flop synchronizer (rx_s); rx_s_d is rx_s delayed one clock; fall = rx_s_d & ~rx_s.
//  16-bit cycle_cnt: cleared in IDLE and on each sample point, else increments. half_pt: cnt==CYCLE/2-1; full_pt: cnt==CYCLE-1.
//  FSM:
//   IDLE   -> START on fall. Level-low without an edge (break, line stuck low) never triggers.
//   START  at half_pt: sample=1 -> IDLE (glitch rejected, no strobe); sample=0 -> DATA, counter cleared (now mid-bit aligned).
//   DATA   at full_pt: data_reg[bit_ptr]<=sample, par^=sample, bit_ptr++; after bit DATA_LEN-1 -> PARITY if enabled, else STOP.
//   PARITY at full_pt: capture pbit -> STOP. Error if ODD: par^pbit!=1; EVEN: par^pbit!=0; SPACE: pbit!=0; MARK: pbit!=1.
//   STOP   at full_pt: frame_err<=~sample; parity_err, data_out<=data_reg; data_valid<=1 next clock; -> IDLE immediately
//          (mid-stop), so the next start edge is caught even with ONEHALF/TWO or back-to-back frames.
//  data_valid is exactly one clock wide; outputs hold until the next strobe. Strobe issued even when an error flag is set.
//  Latency: data_valid rises 1 clk after the mid-stop sample = ~2 (sync) + CYCLE/2 + (DATA_LEN+1+P)*CYCLE + 1 clks after the line falls.
//  rx stuck low after frame: stop sample 0 -> frame_err=1, back to IDLE, waits for high->low edge.
//  Async reset mid-frame: abort immediately, no strobe, outputs to reset values.
//  bit_ptr and par cleared in IDLE; data_reg fully rewritten per frame (unused upper bits held 0).
// CONFIGURATION
//  `UART_RX_MAJORITY_EN defined: sample = 2-of-3 majority of rx_s at counts point-2, point-1, point
//    (3-bit shift of rx_s, voted at the sample point; no added latency).
//  Not defined: sample = rx_s at the sample point (single sample). Timing and strobes are identical in both builds.
// STRUCTURE
//  uart_pkg: parity_e (NONE/ODD/EVEN/SPACE/MARK), stop_e, rx_state_e (IDLE/START/DATA/PARITY/STOP),
//    function bit_cycles(clk_mhz, baud) shared with uart_tx.
//  Sub-module uart_rx_sync: 2-flop synchronizer + fall-edge detect (reset value 1); rest is one FSM + datapath.
// TESTING (CLK_FREQ=50, BAUD_RATE=115200, CYCLE=434; drive rx_in from a bit-accurate model)
//  1 8N1 frame 0xA5 -> one data_valid, data_out=8'hA5, parity_err=0, frame_err=0, busy low after mid-stop.
//  2 PARITY="EVEN", 0x07 with pbit=1 -> parity_err=0; same data, pbit=0 -> parity_err=1, data_out=8'h07.
//  3 rx_in low for 100 clks then high -> no data_valid, busy returns low ~CYCLE/2+3 clks after edge.
//  4 0x3C with stop bit driven 0, then line held low 2000 clks -> frame_err=1, single strobe, no re-trigger until high->low.
//  5 Back-to-back 0x00,0xFF,0x55 with STOP="ONE", DATA_LEN=7 -> three strobes, data_out=00,7F,55 in order.
//  6 rst_n pulsed mid-DATA, then clean 0x81 -> no strobe for aborted frame, next strobe data_out=8'h81;
//    with `UART_RX_MAJORITY_EN, 1-clk glitch at each mid-bit of 0x81 still yields 8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receiver and transmitter.
//   parity_e   : parity mode decoded from the PARITY string parameter
//   stop_e     : stop-bit setting decoded from the STOP string parameter
//   rx_state_e : receiver FSM states
//   bit_cycles : clocks per bit for a given clock (MHz) and baud rate
//   parity_error : parity check of a received frame
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN,
        PAR_SPACE,
        PAR_MARK
    } parity_e;

    typedef enum logic [1:0] {
        STOP_ONE,
        STOP_ONEHALF,
        STOP_TWO
    } stop_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic int bit_cycles(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

    // par is the XOR of all received data bits, pbit the received parity bit.
    function automatic logic parity_error(input parity_e mode, input logic par, input logic pbit);
        case (mode)
            PAR_ODD:   return (par ^ pbit) != 1'b1;
            PAR_EVEN:  return (par ^ pbit) != 1'b0;
            PAR_SPACE: return pbit != 1'b0;
            PAR_MARK:  return pbit != 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side result bus from uart_rx to host/FIFO logic.
//   data_out   : received byte, bits above DATA_LEN are 0
//   data_valid : one-cycle strobe, data_out/parity_err/frame_err updated
//   parity_err : parity mismatch on last frame
//   frame_err  : stop bit sampled low on last frame
//   busy       : receiver not idle
// Modports: master = receiver (drives), slave = consumer.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (output data_out, data_valid, parity_err, frame_err, busy);
    modport slave  (input  data_out, data_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous serial line plus
// falling-edge detect on the synchronized level. All flops reset to 1
// (line idle) so reset release never looks like a start edge.
//   clk, rst_n : clock, async active-low reset
//   rx_in      : raw serial line
//   rx_s       : synchronized line
//   fall       : one-cycle pulse on a synchronized high->low transition
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);
    logic s1;
    logic rx_s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            s1     <= rx_in;
            rx_s   <= s1;
            rx_s_d <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (oversampled by clk).
// Detects the start edge, re-aligns to mid-bit, samples data LSB first,
// optional parity, checks the first stop bit and strobes the result.
//   clk, rst_n : clock, async active-low reset
//   rx_in      : serial line, idle high
//   rx_if      : uart_rx_if.master result bus (data_out, data_valid,
//                parity_err, frame_err, busy)
// Parameters: CLK_FREQ (MHz), BAUD_RATE, DATA_LEN (5..8), PARITY
//   ("NONE"/"ODD"/"EVEN"/"SPACE"/"MARK"), STOP ("ONE"/"ONEHALF"/"TWO";
//   only the first stop bit is ever checked, so it does not change logic).
// Build option: define UART_RX_MAJORITY_EN for a 2-of-3 majority vote of
//   the three synchronized samples ending at each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int    CLK_FREQ  = 50,
    parameter int    BAUD_RATE = 115200,
    parameter int    DATA_LEN  = 8,
    parameter string PARITY    = "NONE",
    parameter string STOP      = "ONE"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    uart_rx_if.master  rx_if
);
    localparam parity_e PAR_MODE = (PARITY == "ODD")   ? PAR_ODD   :
                                   (PARITY == "EVEN")  ? PAR_EVEN  :
                                   (PARITY == "SPACE") ? PAR_SPACE :
                                   (PARITY == "MARK")  ? PAR_MARK  : PAR_NONE;
    localparam bit          PAR_EN   = (PAR_MODE != PAR_NONE);
    localparam int          CYCLE    = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] HALF_PT  = 16'(CYCLE / 2 - 1);
    localparam logic [15:0] FULL_PT  = 16'(CYCLE - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_LEN - 1);

    logic        rx_s;
    logic        fall;
    logic        sample;
    rx_state_e   state_q, state_d;
    logic [15:0] cycle_cnt;
    logic        half_pt, full_pt, sample_pt;
    logic [7:0]  data_reg;
    logic [2:0]  bit_ptr;
    logic        par;
    logic        par_err_q;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .rx_s  (rx_s),
        .fall  (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist[0] = rx_s one clock ago, hist[1] = two clocks ago; vote with the
    // current rx_s so the decision lands on the sample point itself.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    assign half_pt = (cycle_cnt == HALF_PT);
    assign full_pt = (cycle_cnt == FULL_PT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sample_pt = 1'b0;
        case (state_q)
            ST_IDLE: if (fall) state_d = ST_START;
            ST_START: if (half_pt) begin
                sample_pt = 1'b1;
                // line back high by mid-start: treat as glitch
                state_d   = sample ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (full_pt) begin
                sample_pt = 1'b1;
                if (bit_ptr == LAST_BIT) state_d = PAR_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (full_pt) begin
                sample_pt = 1'b1;
                state_d   = ST_STOP;
            end
            ST_STOP: if (full_pt) begin
                sample_pt = 1'b1;
                // leave at mid-stop so a following start edge is never missed
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter restarts at every sample point; after the mid-start sample the
    // FULL_PT hits are therefore at mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cycle_cnt <= '0;
        else if (state_q == ST_IDLE || sample_pt) cycle_cnt <= '0;
        else                                    cycle_cnt <= cycle_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg         <= '0;
            bit_ptr          <= '0;
            par              <= 1'b0;
            par_err_q        <= 1'b0;
            rx_if.data_out   <= '0;
            rx_if.data_valid <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
        end else begin
            rx_if.data_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    data_reg  <= '0;
                    bit_ptr   <= '0;
                    par       <= 1'b0;
                    par_err_q <= 1'b0;
                end
                ST_DATA: if (full_pt) begin
                    data_reg[bit_ptr] <= sample;
                    par               <= par ^ sample;
                    bit_ptr           <= bit_ptr + 3'd1;
                end
                ST_PARITY: if (full_pt) begin
                    par_err_q <= parity_error(PAR_MODE, par, sample);
                end
                ST_STOP: if (full_pt) begin
                    rx_if.frame_err  <= ~sample;
                    rx_if.parity_err <= par_err_q;
                    rx_if.data_out   <= data_reg;
                    rx_if.data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rx_if.busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int CYCLE = 434;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   glitch_en;

    always #10 clk = ~clk;

    uart_rx_if u_if0 ();
    uart_rx_if u_if1 ();
    uart_rx_if u_if2 ();

    // 8N1
    uart_rx #(.CLK_FREQ(50), .BAUD_RATE(115200), .DATA_LEN(8), .PARITY("NONE"), .STOP("ONE"))
        dut0 (.clk(clk), .rst_n(rst_n), .rx_in(rx_line[0]), .rx_if(u_if0));
    // 8E1
    uart_rx #(.CLK_FREQ(50), .BAUD_RATE(115200), .DATA_LEN(8), .PARITY("EVEN"), .STOP("ONE"))
        dut1 (.clk(clk), .rst_n(rst_n), .rx_in(rx_line[1]), .rx_if(u_if1));
    // 7N1
    uart_rx #(.CLK_FREQ(50), .BAUD_RATE(115200), .DATA_LEN(7), .PARITY("NONE"), .STOP("ONE"))
        dut2 (.clk(clk), .rst_n(rst_n), .rx_in(rx_line[2]), .rx_if(u_if2));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_strobe(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe, input exp_t e);
        cmp({tag, " data_out"},   32'(d),  32'(e.d));
        cmp({tag, " parity_err"}, 32'(pe), 32'(e.pe));
        cmp({tag, " frame_err"},  32'(fe), 32'(e.fe));
    endtask

    // Scoreboard monitors: one per receiver, pop on every strobe.
    always @(negedge clk) begin
        if (u_if0.data_valid === 1'b1) begin
            if (q0.size() == 0) cmp("dut0 unexpected strobe", 32'd1, 32'd0);
            else chk_strobe("dut0", u_if0.data_out, u_if0.parity_err, u_if0.frame_err, q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (u_if1.data_valid === 1'b1) begin
            if (q1.size() == 0) cmp("dut1 unexpected strobe", 32'd1, 32'd0);
            else chk_strobe("dut1", u_if1.data_out, u_if1.parity_err, u_if1.frame_err, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (u_if2.data_valid === 1'b1) begin
            if (q2.size() == 0) cmp("dut2 unexpected strobe", 32'd1, 32'd0);
            else chk_strobe("dut2", u_if2.data_out, u_if2.parity_err, u_if2.frame_err, q2.pop_front());
        end
    end

    // Hold line ch at v for n clocks; optional one-clock inversion near mid-bit.
    task automatic hold(input int ch, input logic v, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_line[ch] = (glitch && i == CYCLE / 2 + 2) ? ~v : v;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input int nbits, input bit has_par,
                        input logic pbit, input logic stop_v, input bit glitch);
        hold(ch, 1'b0, CYCLE, 1'b0);
        for (int b = 0; b < nbits; b++) hold(ch, d[b], CYCLE, glitch);
        if (has_par) hold(ch, pbit, CYCLE, glitch);
        hold(ch, stop_v, CYCLE, 1'b0);
    endtask

    initial begin
`ifdef UART_RX_MAJORITY_EN
        glitch_en = 1'b1;
`else
        glitch_en = 1'b0;
`endif
        // reset state
        repeat (5) @(negedge clk);
        cmp("reset data_out",   32'(u_if0.data_out),   32'h0);
        cmp("reset data_valid", 32'(u_if0.data_valid), 32'h0);
        cmp("reset parity_err", 32'(u_if0.parity_err), 32'h0);
        cmp("reset frame_err",  32'(u_if0.frame_err),  32'h0);
        cmp("reset busy",       32'(u_if0.busy),       32'h0);
        cmp("reset busy dut1",  32'(u_if1.busy),       32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 0xA5
        q0.push_back('{8'hA5, 1'b0, 1'b0});
        send(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("busy after mid-stop", 32'(u_if0.busy), 32'h0);

        // short low pulse: start rejected at mid-start
        hold(0, 1'b0, 100, 1'b0);
        cmp("glitch busy high", 32'(u_if0.busy), 32'h1);
        hold(0, 1'b1, 340, 1'b0);
        cmp("glitch busy low", 32'(u_if0.busy), 32'h0);

        // 0x3C with stop low, then line stuck low
        q0.push_back('{8'h3C, 1'b0, 1'b1});
        send(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(0, 1'b0, 2000, 1'b0);
        cmp("stuck low no retrigger", 32'(u_if0.busy), 32'h0);
        hold(0, 1'b1, 50, 1'b0);

        // reset in the middle of a data phase
        hold(0, 1'b0, CYCLE, 1'b0);
        hold(0, 1'b1, 3 * CYCLE, 1'b0);
        cmp("busy mid-data", 32'(u_if0.busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        cmp("midreset data_out",   32'(u_if0.data_out),   32'h0);
        cmp("midreset frame_err",  32'(u_if0.frame_err),  32'h0);
        cmp("midreset data_valid", 32'(u_if0.data_valid), 32'h0);
        cmp("midreset busy",       32'(u_if0.busy),       32'h0);
        rst_n = 1'b1;
        hold(0, 1'b1, 2 * CYCLE, 1'b0);
        q0.push_back('{8'h81, 1'b0, 1'b0});
        send(0, 8'h81, 8, 1'b0, 1'b0, 1'b1, glitch_en);
        hold(0, 1'b1, 50, 1'b0);

        // even parity: 0x07 has three ones, correct pbit is 1
        q1.push_back('{8'h07, 1'b0, 1'b0});
        send(1, 8'h07, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        q1.push_back('{8'h07, 1'b1, 1'b0});
        send(1, 8'h07, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(1, 1'b1, 50, 1'b0);

        // 7N1 back-to-back
        q2.push_back('{8'h00, 1'b0, 1'b0});
        q2.push_back('{8'h7F, 1'b0, 1'b0});
        q2.push_back('{8'h55, 1'b0, 1'b0});
        send(2, 8'h00, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'hFF, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'h55, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b1, 50, 1'b0);

        // every expected strobe must have been consumed
        cmp("dut0 missing strobes", 32'(q0.size()), 32'd0);
        cmp("dut1 missing strobes", 32'(q1.size()), 32'd0);
        cmp("dut2 missing strobes", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
